mod_codec_config_sequencer: RTL

//  Drives mod_i2c_master through a fixed table of audio-codec register writes
//  (WM8731-style: 7-bit register, 9-bit data). Per entry: load operands, pulse
//  the master's reset, wait for success, fault or timeout, then advance.

---
 rtl/mod_codec_config_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mod_codec_config_sequencer.sv
// Walks a fixed WM8731-style codec register table through mod_i2c_master, one write per entry.
// Optional build macro CODEC_CFG_RETRY_EN adds per-entry retries on fault or timeout.
module mod_codec_config_sequencer #(
`ifdef CODEC_CFG_RETRY_EN
   parameter int unsigned MAX_RETRIES    = 2,
`endif
   parameter logic [6:0]  I2C_ADDR       = 7'h1A,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 128
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic [3:0] o_err_index,
   output logic [3:0] o_err_code,
   output logic       o_i2c_nrst,
   output logic [6:0] o_i2c_addr,
   output logic [6:0] o_i2c_register,
   output logic [8:0] o_i2c_data,
   output logic       o_i2c_read_not_write,
   input  logic       i_i2c_done,
   input  logic [3:0] i_i2c_fault_code
);

   localparam int unsigned IDX_W    = 4;
   localparam int unsigned REG_W    = 7;
   localparam int unsigned DATA_W   = 9;
   localparam int unsigned CODE_W   = 4;
   localparam int unsigned LAST_IDX = 10;
   localparam int unsigned RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CODE_W-1:0] CODE_IDLE    = 4'h0;
   localparam logic [CODE_W-1:0] CODE_OK      = 4'hF;
   localparam logic [CODE_W-1:0] CODE_TIMEOUT = 4'hE;

   typedef struct packed {
      logic [REG_W-1:0]  reg_addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_NEXT, S_FAIL, S_DONE, S_ERROR
   } state_t;

   // Codec bring-up table: register address and 9-bit payload per index
   function automatic entry_t table_entry(input logic [IDX_W-1:0] idx);
      entry_t e;
      case (idx)
         4'd0:    e = '{reg_addr: 7'h0F, data: 9'h000};
         4'd1:    e = '{reg_addr: 7'h00, data: 9'h017};
         4'd2:    e = '{reg_addr: 7'h01, data: 9'h017};
         4'd3:    e = '{reg_addr: 7'h02, data: 9'h079};
         4'd4:    e = '{reg_addr: 7'h03, data: 9'h079};
         4'd5:    e = '{reg_addr: 7'h04, data: 9'h012};
         4'd6:    e = '{reg_addr: 7'h05, data: 9'h000};
         4'd7:    e = '{reg_addr: 7'h06, data: 9'h000};
         4'd8:    e = '{reg_addr: 7'h07, data: 9'h042};
         4'd9:    e = '{reg_addr: 7'h08, data: 9'h000};
         4'd10:   e = '{reg_addr: 7'h09, data: 9'h001};
         default: e = '0;
      endcase
      return e;
   endfunction

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [RST_W-1:0]    rcnt_q, rcnt_d;
   logic [TMO_W-1:0]    tcnt_q, tcnt_d;
   logic [CODE_W-1:0]   code_q, code_d;
`ifdef CODEC_CFG_RETRY_EN
   logic [1:0]          retries_q, retries_d;
`endif

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [IDX_W-1:0]    err_index_q, err_index_d;
   logic [CODE_W-1:0]   err_code_q, err_code_d;
   logic                nrst_q, nrst_d;
   logic [REG_W-1:0]    reg_q, reg_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                start_acc;
   entry_t              entry;

   // State and per-entry bookkeeping registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         rcnt_q    <= '0;
         tcnt_q    <= '0;
         code_q    <= '0;
`ifdef CODEC_CFG_RETRY_EN
         retries_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rcnt_q    <= rcnt_d;
         tcnt_q    <= tcnt_d;
         code_q    <= code_d;
`ifdef CODEC_CFG_RETRY_EN
         retries_q <= retries_d;
`endif
      end
   end

   assign start_acc = i_start && (state_q inside {S_IDLE, S_DONE, S_ERROR});

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rcnt_d    = rcnt_q;
      tcnt_d    = tcnt_q;
      code_d    = code_q;
`ifdef CODEC_CFG_RETRY_EN
      retries_d = retries_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_acc) begin
               state_d   = S_LOAD;
               idx_d     = '0;
               rcnt_d    = '0;
`ifdef CODEC_CFG_RETRY_EN
               retries_d = '0;
`endif
            end
         end
         S_LOAD: begin
            if (rcnt_q == RST_W'(RST_CYCLES - 1)) begin
               state_d = S_RUN;
               tcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + RST_W'(1);
            end
         end
         S_RUN: begin
            tcnt_d = tcnt_q + TMO_W'(1);
            if (i_i2c_done && (i_i2c_fault_code == CODE_OK)) begin
               state_d = S_NEXT;
            end else if ((i_i2c_fault_code != CODE_IDLE) && (i_i2c_fault_code != CODE_OK)) begin
               state_d = S_FAIL;
               code_d  = i_i2c_fault_code;
            end else if (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_FAIL;
               code_d  = CODE_TIMEOUT;
            end
         end
         S_NEXT: begin
            if (idx_q == IDX_W'(LAST_IDX)) begin
               state_d = S_DONE;
            end else begin
               state_d   = S_LOAD;
               idx_d     = idx_q + IDX_W'(1);
               rcnt_d    = '0;
`ifdef CODEC_CFG_RETRY_EN
               retries_d = '0;
`endif
            end
         end
         S_FAIL: begin
`ifdef CODEC_CFG_RETRY_EN
            if (32'(retries_q) < MAX_RETRIES) begin
               state_d   = S_LOAD;
               retries_d = retries_q + 2'd1;
               rcnt_d    = '0;
            end else begin
               state_d = S_ERROR;
            end
`else
            state_d = S_ERROR;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output next values, aligned with the state they belong to
   always_comb begin
      busy_d      = state_d inside {S_LOAD, S_RUN, S_NEXT, S_FAIL};
      nrst_d      = (state_d == S_RUN);
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERROR);
      err_index_d = err_index_q;
      err_code_d  = err_code_q;
      reg_d       = reg_q;
      data_d      = data_q;
      entry       = table_entry(idx_d);
      if (start_acc) begin
         err_index_d = '0;
         err_code_d  = '0;
      end
      if ((state_q == S_FAIL) && (state_d == S_ERROR)) begin
         err_index_d = idx_q;
         err_code_d  = code_q;
      end
      if (state_d == S_LOAD) begin
         reg_d  = entry.reg_addr;
         data_d = entry.data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         err_code_q  <= '0;
         nrst_q      <= 1'b0;
         reg_q       <= '0;
         data_q      <= '0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         err_code_q  <= err_code_d;
         nrst_q      <= nrst_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
      end
   end

   assign o_busy               = busy_q;
   assign o_done               = done_q;
   assign o_error              = error_q;
   assign o_err_index          = err_index_q;
   assign o_err_code           = err_code_q;
   assign o_i2c_nrst           = nrst_q;
   assign o_i2c_addr           = I2C_ADDR;
   assign o_i2c_register       = reg_q;
   assign o_i2c_data           = data_q;
   assign o_i2c_read_not_write = 1'b0;

endmodule
